ps2_scan_rx: RTL and testbench

PS2_SCAN_RX -- requirements
Module: ps2_scan_rx

---
 rtl/ps2_pkg.sv | 15 +
 rtl/ps2_filter.sv | 48 ++++
 rtl/ps2_scan_rx.sv | 196 +++++++++++++++++++
 tb/tb_ps2_scan_rx.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT_CODE = 8'hE0;
    localparam logic [7:0] PS2_BRK_CODE = 8'hF0;
    localparam int         PS2_ENTRY_W  = 10;

endpackage

// File: rtl/ps2_filter.sv
// Two-flop synchroniser followed by a debounce counter for one PS/2 line.
module ps2_filter #(
    parameter int DEBOUNCE_MAX = 19
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic filt_o
);

    localparam int CW = $clog2(DEBOUNCE_MAX + 2);

    logic          sync1_q;
    logic          sync2_q;
    logic          filt_q;
    logic          filt_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CW'(DEBOUNCE_MAX)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard frame receiver with E0/F0 prefix folding and an output FIFO.
// Define PS2_PARITY_CHECK_EN to reject frames whose odd parity is wrong.
module ps2_scan_rx
    import ps2_pkg::*;
#(
    parameter int DEBOUNCE_MAX   = 19,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          kclk,
    input  logic                          kdata,
    output logic [PS2_ENTRY_W-1:0]        rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic kclk_f;
    logic kdata_f;
    logic kclk_prev_q;
    logic fall;

    ps2_filter #(.DEBOUNCE_MAX(DEBOUNCE_MAX)) u_clk_filt (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_i  (kclk),
        .filt_o (kclk_f)
    );

    ps2_filter #(.DEBOUNCE_MAX(DEBOUNCE_MAX)) u_dat_filt (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_i  (kdata),
        .filt_o (kdata_f)
    );

    assign fall = kclk_prev_q & ~kclk_f;

    ps2_state_e    state_q, state_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_q, to_d;
    logic          ext_q, ext_d;
    logic          brk_q, brk_d;
    logic          ferr_q, ferr_d;
    logic          push;
    logic [PS2_ENTRY_W-1:0] push_data;
    logic          par_ok;

`ifdef PS2_PARITY_CHECK_EN
    assign par_ok = ^{shift_q, par_q};
`else
    assign par_ok = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_d     = par_q;
        to_d      = '0;
        ext_d     = ext_q;
        brk_d     = brk_q;
        ferr_d    = 1'b0;
        push      = 1'b0;
        push_data = {brk_q, ext_q, shift_q};
        if (state_q != ST_IDLE && !fall) begin
            if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d = ST_IDLE;
                ferr_d  = 1'b1;
            end else begin
                to_d = to_q + 1'b1;
            end
        end else if (fall) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!kdata_f) begin
                        state_d = ST_DATA;
                        bit_d   = '0;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_d = {kdata_f, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    par_d   = kdata_f;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (kdata_f && par_ok) begin
                        if (shift_q == PS2_EXT_CODE) begin
                            ext_d = 1'b1;
                        end else if (shift_q == PS2_BRK_CODE) begin
                            brk_d = 1'b1;
                        end else begin
                            push  = 1'b1;
                            ext_d = 1'b0;
                            brk_d = 1'b0;
                        end
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_q       <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            to_q        <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            ferr_q      <= 1'b0;
            kclk_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            to_q        <= to_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            ferr_q      <= ferr_d;
            kclk_prev_q <= kclk_f;
        end
    end

    logic [PS2_ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          pop;
    logic          full;
    logic          wr_en;

    assign full  = (cnt_q == CW'(FIFO_DEPTH));
    assign pop   = rd_valid & rd_ready;
    // A full FIFO still accepts a push when the head leaves the same cycle.
    assign wr_en = push & (~full | pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = push & full & ~pop;
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (wr_en && !pop) cnt_d = cnt_q + 1'b1;
        else if (pop && !wr_en) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_data;
    end

    assign rd_valid  = (cnt_q != '0);
    assign rd_data   = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign count     = cnt_q;
    assign frame_err = ferr_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Directed bench for ps2_scan_rx: framing, prefixes, parity, timeout, FIFO, filtering.
module tb_ps2_scan_rx;

    localparam int DM    = 4;
    localparam int TO    = 200;
    localparam int DEPTH = 4;
    localparam int HALF  = 20;
    // Raw kclk fall to debounced fall: 2 sync flops + DM+1 samples.
    localparam int EDGE_LAT = DM + 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       kclk = 1'b1;
    logic       kdata = 1'b1;
    logic [9:0] rd_data;
    logic       rd_valid;
    logic       rd_ready = 1'b0;
    logic [2:0] count;
    logic       frame_err;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int ferr_n = 0;
    int ovf_n = 0;

    ps2_scan_rx #(
        .DEBOUNCE_MAX   (DM),
        .TIMEOUT_CYCLES (TO),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .kclk      (kclk),
        .kdata     (kdata),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .count     (count),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) ferr_n++;
        if (overflow) ovf_n++;
    end

    task automatic ps2_bit(input logic b);
        kdata = b;
        repeat (HALF) @(posedge clk);
        #1 kclk = 1'b0;
        repeat (HALF) @(posedge clk);
        #1 kclk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par,
                              input logic pop_at_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(bad_par ? ^d : ~^d);
        kdata = 1'b1;
        repeat (HALF) @(posedge clk);
        #1 kclk = 1'b0;
        if (pop_at_stop) begin
            repeat (EDGE_LAT) @(posedge clk);
            #1 rd_ready = 1'b1;
            @(posedge clk);
            #1 rd_ready = 1'b0;
            repeat (HALF - EDGE_LAT - 1) @(posedge clk);
        end else begin
            repeat (HALF) @(posedge clk);
        end
        #1 kclk = 1'b1;
        repeat (HALF) @(posedge clk);
        #1;
    endtask

    task automatic pop(output logic [9:0] d, output logic v);
        @(negedge clk);
        d = rd_data;
        v = rd_valid;
        @(posedge clk);
        #1 rd_ready = 1'b1;
        @(posedge clk);
        #1 rd_ready = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b want 0", rd_valid);
        end
        checks++;
        if (count !== 3'd0) begin
            errors++; $display("FAIL reset_count got %0d want 0", count);
        end
        checks++;
        if (rd_data !== 10'h000) begin
            errors++; $display("FAIL reset_data got %h want 000", rd_data);
        end
        checks++;
        if (frame_err !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses got %b%b want 00", frame_err, overflow);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_single;
        logic [9:0] d;
        logic v;
        int f0;
        f0 = ferr_n;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d_1c(i));
        ps2_bit(1'b0);
        kdata = 1'b1;
        repeat (HALF) @(posedge clk);
        #1 kclk = 1'b0;
        repeat (EDGE_LAT) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++; $display("FAIL single_early got %b want 0", rd_valid);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 10'h01C) begin
            errors++;
            $display("FAIL single_latency got v=%b d=%h want v=1 d=01C",
                     rd_valid, rd_data);
        end
        repeat (HALF - EDGE_LAT - 1) @(posedge clk);
        #1 kclk = 1'b1;
        repeat (HALF) @(posedge clk);
        #1;
        checks++;
        if (count !== 3'd1 || ferr_n != f0) begin
            errors++;
            $display("FAIL single_count got %0d/%0d want 1/0", count, ferr_n - f0);
        end
        pop(d, v);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (count !== 3'd0 || rd_valid !== 1'b0) begin
            errors++; $display("FAIL single_pop got %0d want 0", count);
        end
        #1;
    endtask

    function automatic logic d_1c(input int i);
        logic [7:0] c;
        c = 8'h1C;
        return c[i];
    endfunction

    task automatic test_prefix;
        logic [9:0] d;
        logic v;
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        checks++;
        if (count !== 3'd0) begin
            errors++; $display("FAIL prefix_nopush got %0d want 0", count);
        end
        send_frame(8'h75, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        checks++;
        if (count !== 3'd2) begin
            errors++; $display("FAIL prefix_count got %0d want 2", count);
        end
        pop(d, v);
        checks++;
        if (v !== 1'b1 || d !== 10'h375) begin
            errors++; $display("FAIL prefix_first got %h want 375", d);
        end
        pop(d, v);
        checks++;
        if (v !== 1'b1 || d !== 10'h075) begin
            errors++; $display("FAIL prefix_second got %h want 075", d);
        end
    endtask

    task automatic test_bad_parity;
        logic [9:0] d;
        logic v;
        int f0;
        f0 = ferr_n;
        send_frame(8'h1C, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
        checks++;
        if (count !== 3'd0 || ferr_n - f0 != 1) begin
            errors++;
            $display("FAIL parity_reject got cnt=%0d err=%0d want 0/1",
                     count, ferr_n - f0);
        end
`else
        checks++;
        if (count !== 3'd1 || ferr_n != f0) begin
            errors++;
            $display("FAIL parity_ignore got cnt=%0d err=%0d want 1/0",
                     count, ferr_n - f0);
        end
        pop(d, v);
        checks++;
        if (d !== 10'h01C) begin
            errors++; $display("FAIL parity_data got %h want 01C", d);
        end
`endif
    endtask

    task automatic test_timeout;
        logic [9:0] d;
        logic v;
        int f0;
        f0 = ferr_n;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (TO + 60) @(posedge clk);
        #1;
        checks++;
        if (ferr_n - f0 != 1 || count !== 3'd0) begin
            errors++;
            $display("FAIL timeout_err got err=%0d cnt=%0d want 1/0",
                     ferr_n - f0, count);
        end
        send_frame(8'h29, 1'b0, 1'b0);
        pop(d, v);
        checks++;
        if (v !== 1'b1 || d !== 10'h029 || ferr_n - f0 != 1) begin
            errors++; $display("FAIL timeout_next got %h want 029", d);
        end
    endtask

    task automatic test_overflow;
        logic [9:0] d;
        logic v;
        logic [7:0] exp_q [4];
        int o0;
        o0 = ovf_n;
        for (int i = 0; i < DEPTH + 1; i++)
            send_frame(8'(8'h15 + i), 1'b0, 1'b0);
        checks++;
        if (count !== 3'd4 || ovf_n - o0 != 1) begin
            errors++;
            $display("FAIL ovf_full got cnt=%0d ovf=%0d want 4/1", count, ovf_n - o0);
        end
        send_frame(8'h1A, 1'b0, 1'b1);
        checks++;
        if (count !== 3'd4 || ovf_n - o0 != 1) begin
            errors++;
            $display("FAIL ovf_pushpop got cnt=%0d ovf=%0d want 4/1",
                     count, ovf_n - o0);
        end
        exp_q[0] = 8'h16;
        exp_q[1] = 8'h17;
        exp_q[2] = 8'h18;
        exp_q[3] = 8'h1A;
        for (int i = 0; i < 4; i++) begin
            pop(d, v);
            checks++;
            if (v !== 1'b1 || d !== {2'b00, exp_q[i]}) begin
                errors++;
                $display("FAIL ovf_drain%0d got %h want %h", i, d, {2'b00, exp_q[i]});
            end
        end
        pop(d, v);
        checks++;
        if (v !== 1'b0 || count !== 3'd0) begin
            errors++; $display("FAIL ovf_empty got v=%b cnt=%0d want 0/0", v, count);
        end
    endtask

    task automatic test_glitch_reset;
        logic [9:0] d;
        logic v;
        int f0;
        f0 = ferr_n;
        kdata = 1'b1;
        #1 kclk = 1'b0;
        repeat (2) @(posedge clk);
        #1 kclk = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if (ferr_n != f0 || count !== 3'd0) begin
            errors++; $display("FAIL glitch got err=%0d want 0", ferr_n - f0);
        end
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        kdata = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0 || count !== 3'd0) begin
            errors++; $display("FAIL midreset got v=%b want 0", rd_valid);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        f0 = ferr_n;
        repeat (20) @(posedge clk);
        #1;
        send_frame(8'h5A, 1'b0, 1'b0);
        pop(d, v);
        checks++;
        if (v !== 1'b1 || d !== 10'h05A || ferr_n != f0) begin
            errors++;
            $display("FAIL after_reset got %h err=%0d want 05A/0", d, ferr_n - f0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_prefix();
        test_bad_parity();
        test_timeout();
        test_overflow();
        test_glitch_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
